// File: rtl/aes_pkg.sv
// AES shared definitions: word types, S-box, Rcon and key-schedule FSM states.
// Used by both the forward and the reverse key expansion.
package aes_pkg;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed by round number; entry 0 and 11..15 are never used
  localparam byte_t RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_inv_key_expansion_if.sv
// Control and key-stream bundle of the reverse AES-128 key schedule.
interface aes_inv_key_expansion_if;
  import aes_pkg::*;

  logic       start;
  key_t       key_in;
  logic       out_ready;
  logic       busy;
  logic       key_valid;
  key_t       round_key;
  logic [3:0] round_idx;
  logic       done;

  modport master (
    output start,
    output key_in,
    output out_ready,
    input  busy,
    input  key_valid,
    input  round_key,
    input  round_idx,
    input  done
  );

  modport slave (
    input  start,
    input  key_in,
    input  out_ready,
    output busy,
    output key_valid,
    output round_key,
    output round_idx,
    output done
  );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  assign o_word[31:24] = sbox(i_word[31:24]);
  assign o_word[23:16] = sbox(i_word[23:16]);
  assign o_word[15:8]  = sbox(i_word[15:8]);
  assign o_word[7:0]   = sbox(i_word[7:0]);

endmodule

// File: rtl/aes_inv_key_expansion.sv
// Reverse AES-128 key schedule: streams round keys 10 down to 0
// from the last round key, one per accepted cycle.
module aes_inv_key_expansion
  import aes_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  aes_inv_key_expansion_if.slave   bus
);

  state_t     r_state;
  state_t     w_next_state;
  key_t       r_key;
  logic [3:0] r_idx;
  logic       r_done;

  logic w_load;
  logic w_step;
  logic w_finish;

  word_t w_k0, w_k1, w_k2, w_k3;
  word_t w_p0, w_p1, w_p2, w_p3;
  word_t w_rot;
  word_t w_sub;

  assign {w_k0, w_k1, w_k2, w_k3} = r_key;

  // w_p3 is the last word of the previous round, which feeds its g()
  assign w_p3  = w_k3 ^ w_k2;
  assign w_p2  = w_k2 ^ w_k1;
  assign w_p1  = w_k1 ^ w_k0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  aes_sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_p0 = w_k0 ^ w_sub ^ {RCON[r_idx], 24'h0};

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          if (r_idx == 4'd0) begin
            w_next_state = IDLE;
            w_finish     = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_finish;
      if (w_load) begin
        r_key <= bus.key_in;
        r_idx <= 4'd10;
      end else if (w_step) begin
        r_key <= {w_p0, w_p1, w_p2, w_p3};
        r_idx <= r_idx - 4'd1;
      end
    end
  end

  assign bus.busy      = (r_state == RUN);
  assign bus.key_valid = (r_state == RUN);
  assign bus.round_key = r_key;
  assign bus.round_idx = r_idx;
  assign bus.done      = r_done;

endmodule
